// File: rtl/lift_request_ctrl.sv
// Lift request controller: latches floor-button presses, reports the travel
// bounds (highest/lowest pending floor) to the lift state block, and holds the
// lift at a requested floor for a fixed door dwell before clearing that request.
module lift_request_ctrl #(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] requests,
    output logic [FLOOR_W-1:0]    max_request,
    output logic [FLOOR_W-1:0]    min_request,
    output logic                  door_open,
    output logic                  served_valid,
    output logic [FLOOR_W-1:0]    served_floor
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] DOOR = 1'b1;

    logic [0:0]            state;
    logic [7:0]            dwell_cnt;
    logic                  here_req;
    logic                  last_door;
    logic                  hold;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [FLOOR_W-1:0]    hi_idx;
    logic [FLOOR_W-1:0]    lo_idx;

    assign here_req   = requests[current_floor];
    assign last_door  = (state == DOOR) && (dwell_cnt == 8'd0);
    assign hold       = (state == DOOR) || ((state == RUN) && here_req);
    // Only the floor being served is cleared, and only as the door closes.
    assign clear_mask = last_door ? (NUM_FLOORS'(1) << current_floor) : '0;

    // Highest and lowest set bit of the pending-request vector.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (requests[i]) hi_idx = FLOOR_W'(i);
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (requests[i]) lo_idx = FLOOR_W'(i);
    end

    // Pin both bounds to the current floor while stopped or idle so the lift
    // does not move away on the same edge it arrives at a requested floor.
    always_comb begin
        if (hold || (requests == '0)) begin
            max_request = current_floor;
            min_request = current_floor;
        end else begin
            max_request = hi_idx;
            min_request = lo_idx;
        end
    end

    // Pending requests: new presses OR in, the served floor drops out (clear wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) requests <= '0;
        else       requests <= (requests | btn_req) & ~clear_mask;
    end

    // RUN/DOOR dwell machine with one-cycle served pulse on door close.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            dwell_cnt    <= 8'd0;
            door_open    <= 1'b0;
            served_valid <= 1'b0;
            served_floor <= '0;
        end else begin
            served_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (here_req) begin
                        state     <= DOOR;
                        dwell_cnt <= 8'(DOOR_CYCLES - 1);
                        door_open <= 1'b1;
                    end else begin
                        door_open <= 1'b0;
                    end
                end
                default: begin
                    if (dwell_cnt != 8'd0) begin
                        dwell_cnt <= dwell_cnt - 8'd1;
                        door_open <= 1'b1;
                    end else begin
                        state        <= RUN;
                        door_open    <= 1'b0;
                        served_valid <= 1'b1;
                        served_floor <= current_floor;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lift_request_ctrl.sv
// Directed bench for lift_request_ctrl: a default build (4-cycle dwell) and a
// 1-cycle-dwell build share clock and reset. Inputs change and outputs are
// sampled 2 time units after each rising edge.
module tb_lift_request_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] btn_req, requests;
    logic [2:0] current_floor, max_request, min_request, served_floor;
    logic       door_open, served_valid;

    logic [7:0] b_btn_req, b_requests;
    logic [2:0] b_current_floor, b_max_request, b_min_request, b_served_floor;
    logic       b_door_open, b_served_valid;

    int checks = 0;
    int errors = 0;

    lift_request_ctrl #(.NUM_FLOORS(8), .FLOOR_W(3), .DOOR_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .btn_req(btn_req), .current_floor(current_floor),
        .requests(requests), .max_request(max_request), .min_request(min_request),
        .door_open(door_open), .served_valid(served_valid), .served_floor(served_floor)
    );

    lift_request_ctrl #(.NUM_FLOORS(8), .FLOOR_W(3), .DOOR_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .btn_req(b_btn_req), .current_floor(b_current_floor),
        .requests(b_requests), .max_request(b_max_request), .min_request(b_min_request),
        .door_open(b_door_open), .served_valid(b_served_valid), .served_floor(b_served_floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_req = '0;
        b_btn_req = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        current_floor = 3'd0;
        b_current_floor = 3'd0;
        btn_req = '0;
        b_btn_req = '0;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (requests !== 8'h00 || door_open !== 1'b0 || served_valid !== 1'b0 || served_floor !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: req=%h door=%b sv=%b sf=%0d, want 00 0 0 0", requests, door_open, served_valid, served_floor);
        end
        current_floor = 3'd5;
        #1;
        checks++;
        if (max_request !== 3'd5 || min_request !== 3'd5) begin
            errors++;
            $display("FAIL reset_bounds: max=%0d min=%0d, want 5 5", max_request, min_request);
        end
        current_floor = 3'd0;
        reset = 1'b0;
    endtask

    task automatic test_latch();
        current_floor = 3'd0;
        btn_req = 8'b0001_0000;
        tick();
        btn_req = '0;
        checks++;
        if (requests !== 8'h10 || max_request !== 3'd4 || min_request !== 3'd4 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL latch: req=%h max=%0d min=%0d door=%b, want 10 4 4 0", requests, max_request, min_request, door_open);
        end
    endtask

    task automatic test_dwell();
        int door_hi;
        current_floor = 3'd4;
        #1;
        checks++;
        if (max_request !== 3'd4 || min_request !== 3'd4 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL arrive_hold: max=%0d min=%0d door=%b, want 4 4 0", max_request, min_request, door_open);
        end
        door_hi = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (door_open === 1'b1) door_hi++;
        end
        checks++;
        if (door_hi != 4 || requests !== 8'h10 || served_valid !== 1'b0) begin
            errors++;
            $display("FAIL dwell_body: door_hi=%0d req=%h sv=%b, want 4 10 0", door_hi, requests, served_valid);
        end
        tick();
        checks++;
        if (door_open !== 1'b0 || served_valid !== 1'b1 || served_floor !== 3'd4 || requests !== 8'h00) begin
            errors++;
            $display("FAIL dwell_close: door=%b sv=%b sf=%0d req=%h, want 0 1 4 00", door_open, served_valid, served_floor, requests);
        end
        tick();
        checks++;
        if (served_valid !== 1'b0 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL served_pulse_width: sv=%b door=%b, want 0 0", served_valid, door_open);
        end
    endtask

    task automatic test_minmax();
        do_reset();
        current_floor = 3'd3;
        btn_req = 8'h82;
        tick();
        btn_req = '0;
        checks++;
        if (requests !== 8'h82 || max_request !== 3'd7 || min_request !== 3'd1) begin
            errors++;
            $display("FAIL minmax: req=%h max=%0d min=%0d, want 82 7 1", requests, max_request, min_request);
        end
        btn_req = 8'h08;
        tick();
        btn_req = '0;
        tick();
        btn_req = 8'h20;
        tick();
        btn_req = '0;
        checks++;
        if (requests !== 8'haa || max_request !== 3'd3 || min_request !== 3'd3 || door_open !== 1'b1) begin
            errors++;
            $display("FAIL press_in_door: req=%h max=%0d min=%0d door=%b, want aa 3 3 1", requests, max_request, min_request, door_open);
        end
        tick();
        tick();
        tick();
        checks++;
        if (requests !== 8'ha2 || served_valid !== 1'b1 || served_floor !== 3'd3 || max_request !== 3'd7 || min_request !== 3'd1) begin
            errors++;
            $display("FAIL after_door3: req=%h sv=%b sf=%0d max=%0d min=%0d, want a2 1 3 7 1", requests, served_valid, served_floor, max_request, min_request);
        end
    endtask

    task automatic test_repress();
        int door_hi, pulses;
        do_reset();
        current_floor = 3'd2;
        btn_req = 8'h04;
        tick();
        btn_req = '0;
        tick();
        tick();
        tick();
        tick();
        btn_req = 8'h04;
        tick();
        btn_req = '0;
        checks++;
        if (requests !== 8'h00 || served_valid !== 1'b1 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: req=%h sv=%b door=%b, want 00 1 0", requests, served_valid, door_open);
        end
        tick();
        checks++;
        if (requests !== 8'h00 || served_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: req=%h sv=%b, want 00 0", requests, served_valid);
        end
        btn_req = 8'h04;
        tick();
        btn_req = '0;
        door_hi = 0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (door_open === 1'b1) door_hi++;
            if (served_valid === 1'b1) pulses++;
        end
        checks++;
        if (door_hi != 4 || pulses != 1 || requests !== 8'h00) begin
            errors++;
            $display("FAIL redwell: door_hi=%0d pulses=%0d req=%h, want 4 1 00", door_hi, pulses, requests);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        current_floor = 3'd5;
        btn_req = 8'h24;
        tick();
        btn_req = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (requests !== 8'h00 || door_open !== 1'b0 || served_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: req=%h door=%b sv=%b, want 00 0 0", requests, door_open, served_valid);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (served_valid !== 1'b0 || door_open !== 1'b0 || max_request !== 3'd5 || min_request !== 3'd5) begin
            errors++;
            $display("FAIL reset_release: sv=%b door=%b max=%0d min=%0d, want 0 0 5 5", served_valid, door_open, max_request, min_request);
        end
        current_floor = 3'd6;
        #1;
        checks++;
        if (max_request !== 3'd6 || min_request !== 3'd6) begin
            errors++;
            $display("FAIL idle_bounds: max=%0d min=%0d, want 6 6", max_request, min_request);
        end
    endtask

    task automatic test_door1();
        do_reset();
        b_current_floor = 3'd2;
        b_btn_req = 8'h04;
        tick();
        b_btn_req = '0;
        tick();
        checks++;
        if (b_door_open !== 1'b1 || b_served_valid !== 1'b0 || b_requests !== 8'h04) begin
            errors++;
            $display("FAIL d1_open: door=%b sv=%b req=%h, want 1 0 04", b_door_open, b_served_valid, b_requests);
        end
        tick();
        checks++;
        if (b_door_open !== 1'b0 || b_served_valid !== 1'b1 || b_served_floor !== 3'd2 || b_requests !== 8'h00) begin
            errors++;
            $display("FAIL d1_close: door=%b sv=%b sf=%0d req=%h, want 0 1 2 00", b_door_open, b_served_valid, b_served_floor, b_requests);
        end
        b_btn_req = 8'h80;
        tick();
        b_btn_req = '0;
        checks++;
        if (b_served_valid !== 1'b0 || b_door_open !== 1'b0 || b_max_request !== 3'd7 || b_min_request !== 3'd7) begin
            errors++;
            $display("FAIL d1_free: sv=%b door=%b max=%0d min=%0d, want 0 0 7 7", b_served_valid, b_door_open, b_max_request, b_min_request);
        end
    endtask

    initial begin
        test_reset();
        test_latch();
        test_dwell();
        test_minmax();
        test_repress();
        test_reset_mid();
        test_door1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
